// File: rtl/bios_bus_pkg.sv
// Shared types for the BIOS/boot RAM request bus.
// One request bundle per requester; owner ids name the issuer recorded for a read.
package bios_bus_pkg;

  localparam int BIOS_TW = 21;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef struct packed {
    logic               act;
    logic               cmd;
    logic [31:0]        addr;
    logic [7:0]         be;
    logic [63:0]        dti;
    logic [BIOS_TW-1:0] tag;
  } bios_req_t;

  // Eligible to be offered to memory: writes always, reads only while the owner FIFO has room.
  function automatic logic req_eligible(bios_req_t r, logic fifo_full);
    return r.act & (~r.cmd | ~fifo_full);
  endfunction

endpackage

// File: rtl/bios_order_fifo.sv
// In-order owner FIFO: one bit per outstanding read naming the requester that issued it.
// Callers never push while full nor pop while empty.
module bios_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic CLKH,
  input  logic RESET,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge CLKH or negedge RESET) begin
    if (!RESET) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/bios_ram_arbiter.sv
// Round-robin arbiter sharing the BIOS RAM port between requester A (CPU) and B (boot loader/DMA).
// Requests pass through combinationally; read responses return one cycle later to their issuer.
module bios_ram_arbiter
  import bios_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TW    = BIOS_TW
) (
  input  logic          CLKH,
  input  logic          RESET,
  input  logic          A_ACT,
  input  logic          A_CMD,
  input  logic [31:0]   A_ADDR,
  input  logic [7:0]    A_BE,
  input  logic [63:0]   A_DTI,
  input  logic [TW-1:0] A_TAGI,
  input  logic          B_ACT,
  input  logic          B_CMD,
  input  logic [31:0]   B_ADDR,
  input  logic [7:0]    B_BE,
  input  logic [63:0]   B_DTI,
  input  logic [TW-1:0] B_TAGI,
  output logic          A_NEXT,
  output logic          A_DRDY,
  output logic [63:0]   A_DTO,
  output logic [TW-1:0] A_TAGO,
  output logic          B_NEXT,
  output logic          B_DRDY,
  output logic [63:0]   B_DTO,
  output logic [TW-1:0] B_TAGO,
  output logic          M_ACT,
  output logic          M_CMD,
  output logic [31:0]   M_ADDR,
  output logic [7:0]    M_BE,
  output logic [63:0]   M_DTI,
  output logic [TW-1:0] M_TAGI,
  input  logic          M_NEXT,
  input  logic          M_DRDY,
  input  logic [63:0]   M_DTO,
  input  logic [TW-1:0] M_TAGO,
  output logic          ERR
);

  bios_req_t req_a, req_b, req_m;
  logic      fifo_full, fifo_empty, fifo_head;
  logic      elig_a, elig_b, grant_b, any_grant, xfer;
  logic      push, pop, last;

  assign req_a = '{act: A_ACT, cmd: A_CMD, addr: A_ADDR, be: A_BE, dti: A_DTI, tag: A_TAGI};
  assign req_b = '{act: B_ACT, cmd: B_CMD, addr: B_ADDR, be: B_BE, dti: B_DTI, tag: B_TAGI};

  // Full flag is the registered one, so a same-cycle pop never unblocks a read.
  assign elig_a    = req_eligible(req_a, fifo_full);
  assign elig_b    = req_eligible(req_b, fifo_full);
  assign grant_b   = elig_b & (~elig_a | (last == OWNER_A));
  assign any_grant = elig_a | elig_b;

  always_comb begin
    req_m = '0;
    if (grant_b) begin
      req_m = req_b;
    end else if (elig_a) begin
      req_m = req_a;
    end
  end

  assign M_ACT  = any_grant;
  assign M_CMD  = req_m.cmd;
  assign M_ADDR = req_m.addr;
  assign M_BE   = req_m.be;
  assign M_DTI  = req_m.dti;
  assign M_TAGI = req_m.tag;

  assign A_NEXT = elig_a & ~grant_b & M_NEXT;
  assign B_NEXT = grant_b & M_NEXT;

  assign xfer = any_grant & M_NEXT;
  assign push = xfer & req_m.cmd;
  assign pop  = M_DRDY & ~fifo_empty;

  bios_order_fifo #(.DEPTH(DEPTH)) u_order_fifo (
    .CLKH  (CLKH),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .din   (grant_b),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge CLKH or negedge RESET) begin
    if (!RESET) begin
      last <= OWNER_B;
    end else if (xfer) begin
      last <= grant_b;
    end
  end

  // Non-owner data/tag hold their last value; only DRDY pulses.
  always_ff @(posedge CLKH or negedge RESET) begin
    if (!RESET) begin
      A_DRDY <= 1'b0;
      A_DTO  <= '0;
      A_TAGO <= '0;
      B_DRDY <= 1'b0;
      B_DTO  <= '0;
      B_TAGO <= '0;
      ERR    <= 1'b0;
    end else begin
      A_DRDY <= pop & (fifo_head == OWNER_A);
      B_DRDY <= pop & (fifo_head == OWNER_B);
      if (pop && fifo_head == OWNER_A) begin
        A_DTO  <= M_DTO;
        A_TAGO <= M_TAGO;
      end
      if (pop && fifo_head == OWNER_B) begin
        B_DTO  <= M_DTO;
        B_TAGO <= M_TAGO;
      end
      if (M_DRDY && fifo_empty) begin
        ERR <= 1'b1;
      end
    end
  end

endmodule
